// File: rtl/mouse_pos_delay_line.sv
// Mouse-position delay line: clamps coordinates to the screen, delays them by a runtime-selectable
// number of stages, and masks valid_out while the pipe refills. Optional `moved` flag: MOUSE_DELAY_MOVED_EN.
module mouse_pos_delay_line #(
    parameter int W     = 12,
    parameter int DEPTH = 4,
    parameter int XMAX  = 1023,
    parameter int YMAX  = 767,
    parameter int SW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  xpos_mouse_in,
    input  logic [W-1:0]  ypos_mouse_in,
    input  logic          valid_in,
    input  logic          freeze,
    input  logic [SW-1:0] delay_sel,
    output logic [W-1:0]  xpos_mouse_out,
    output logic [W-1:0]  ypos_mouse_out,
    output logic          valid_out,
    output logic          settling
`ifdef MOUSE_DELAY_MOVED_EN
    ,
    output logic          moved
`endif
);

    localparam int CW = $clog2(DEPTH + 2);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [W-1:0]  XLIM  = XMAX[W-1:0];
    localparam logic [W-1:0]  YLIM  = YMAX[W-1:0];
    localparam logic [SW-1:0] D_MAX = SW'(DEPTH);

    typedef enum logic {IDLE, SETTLE} state_t;

    function automatic logic [W-1:0] clamp(input logic [W-1:0] v, input logic [W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    logic [W-1:0]  r_x [DEPTH];
    logic [W-1:0]  r_y [DEPTH];
    logic          r_v [DEPTH];
    logic [W-1:0]  r_xo, r_yo;
    logic          r_vo;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [SW-1:0] r_dsel, w_dsel_nxt;

    logic [W-1:0]  w_xc, w_yc;
    logic [SW-1:0] w_d;
    logic [IW-1:0] w_tap;
    logic [W-1:0]  w_tx, w_ty;
    logic          w_tv;
    logic          w_vo_nxt;

    // Stage 0 entry: clamp and saturate the requested delay
    always_comb begin
        w_xc  = clamp(xpos_mouse_in, XLIM);
        w_yc  = clamp(ypos_mouse_in, YLIM);
        w_d   = (delay_sel > D_MAX) ? D_MAX : delay_sel;
        w_tap = IW'(w_d - 1'b1);
    end

    // Tap select: delay 0 bypasses the pipe entirely
    always_comb begin
        w_tx = w_xc;
        w_ty = w_yc;
        w_tv = valid_in;
        if (w_d != '0) begin
            w_tx = r_x[w_tap];
            w_ty = r_y[w_tap];
            w_tv = r_v[w_tap];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dsel_nxt  = r_dsel;
        if (!freeze) begin
            if (w_d != r_dsel) begin
                // A new delay restarts the refill window, also from within SETTLE
                w_dsel_nxt  = w_d;
                w_cnt_nxt   = CW'(w_d) + CW'(1);
                w_state_nxt = SETTLE;
            end else begin
                case (r_state)
                    IDLE: ;
                    SETTLE: begin
                        if (r_cnt == CW'(1)) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = IDLE;
                        end else begin
                            w_cnt_nxt = r_cnt - CW'(1);
                        end
                    end
                    default: w_state_nxt = IDLE;
                endcase
            end
        end
        w_vo_nxt = (w_state_nxt == SETTLE) ? 1'b0 : w_tv;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_x[k] <= '0;
                r_y[k] <= '0;
                r_v[k] <= 1'b0;
            end
            r_xo    <= '0;
            r_yo    <= '0;
            r_vo    <= 1'b0;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dsel  <= w_d;
        end else if (!freeze) begin
            r_x[0] <= w_xc;
            r_y[0] <= w_yc;
            r_v[0] <= valid_in;
            for (int k = 1; k < DEPTH; k++) begin
                r_x[k] <= r_x[k-1];
                r_y[k] <= r_y[k-1];
                r_v[k] <= r_v[k-1];
            end
            r_xo    <= w_tx;
            r_yo    <= w_ty;
            r_vo    <= w_vo_nxt;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dsel  <= w_dsel_nxt;
        end
    end

`ifdef MOUSE_DELAY_MOVED_EN
    logic [2*W-1:0] r_last;
    logic           r_moved;

    // Moved compares the pair about to be presented against the last one presented as valid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last  <= '0;
            r_moved <= 1'b0;
        end else if (freeze) begin
            r_moved <= 1'b0;
        end else begin
            r_moved <= w_vo_nxt && ({w_tx, w_ty} != r_last);
            if (w_vo_nxt) begin
                r_last <= {w_tx, w_ty};
            end
        end
    end

    assign moved = r_moved;
`endif

    assign xpos_mouse_out = r_xo;
    assign ypos_mouse_out = r_yo;
    assign valid_out      = r_vo;
    assign settling       = (r_state == SETTLE);

endmodule

// File: tb/tb_mouse_pos_delay_line.sv
// Directed bench for mouse_pos_delay_line (default W=12, DEPTH=4, XMAX=1023, YMAX=767).
module tb_mouse_pos_delay_line;

    localparam int W  = 12;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  xin, yin;
    logic          vin;
    logic          freeze;
    logic [SW-1:0] delay_sel;
    logic [W-1:0]  xout, yout;
    logic          vout;
    logic          settling;
`ifdef MOUSE_DELAY_MOVED_EN
    logic          moved;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    mouse_pos_delay_line dut (
        .clk            (clk),
        .rst            (rst),
        .xpos_mouse_in  (xin),
        .ypos_mouse_in  (yin),
        .valid_in       (vin),
        .freeze         (freeze),
        .delay_sel      (delay_sel),
        .xpos_mouse_out (xout),
        .ypos_mouse_out (yout),
        .valid_out      (vout),
        .settling       (settling)
`ifdef MOUSE_DELAY_MOVED_EN
        ,
        .moved          (moved)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [SW-1:0] sel);
        rst = 1'b1; freeze = 1'b0; vin = 1'b0; xin = '0; yin = '0; delay_sel = sel;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(3'd0);
        n_checks++; if (xout !== 12'd0) $display("FAIL reset_x got %0d exp 0", xout); else n_pass++;
        n_checks++; if (yout !== 12'd0) $display("FAIL reset_y got %0d exp 0", yout); else n_pass++;
        n_checks++; if (vout !== 1'b0) $display("FAIL reset_valid got %b exp 0", vout); else n_pass++;
        n_checks++; if (settling !== 1'b0) $display("FAIL reset_settling got %b exp 0", settling); else n_pass++;
        step();
        n_checks++; if (settling !== 1'b0) $display("FAIL post_reset_settling got %b exp 0", settling); else n_pass++;
    endtask

    task automatic test_delay0();
        do_reset(3'd0);
        xin = 12'd100; yin = 12'd50; vin = 1'b1;
        step();
        n_checks++; if (xout !== 12'd100) $display("FAIL d0_x got %0d exp 100", xout); else n_pass++;
        n_checks++; if (yout !== 12'd50) $display("FAIL d0_y got %0d exp 50", yout); else n_pass++;
        n_checks++; if (vout !== 1'b1) $display("FAIL d0_valid got %b exp 1", vout); else n_pass++;
        vin = 1'b0;
        step();
        n_checks++; if (vout !== 1'b0) $display("FAIL d0_invalid got %b exp 0", vout); else n_pass++;
    endtask

    task automatic test_clamp();
        do_reset(3'd0);
        xin = 12'd2000; yin = 12'd900; vin = 1'b1;
        step();
        n_checks++; if (xout !== 12'd1023) $display("FAIL clamp_x got %0d exp 1023", xout); else n_pass++;
        n_checks++; if (yout !== 12'd767) $display("FAIL clamp_y got %0d exp 767", yout); else n_pass++;
        xin = 12'd1023; yin = 12'd767;
        step();
        n_checks++; if (xout !== 12'd1023) $display("FAIL edge_x got %0d exp 1023", xout); else n_pass++;
        n_checks++; if (yout !== 12'd767) $display("FAIL edge_y got %0d exp 767", yout); else n_pass++;
        xin = 12'd1024; yin = 12'd768;
        step();
        n_checks++; if (xout !== 12'd1023) $display("FAIL over1_x got %0d exp 1023", xout); else n_pass++;
        n_checks++; if (yout !== 12'd767) $display("FAIL over1_y got %0d exp 767", yout); else n_pass++;
    endtask

    task automatic test_ramp_d3();
        logic [W-1:0] ex;
        logic         ev;
        do_reset(3'd3);
        for (int i = 0; i < 10; i++) begin
            xin = W'(i + 1); yin = W'(i); vin = (i != 5);
            step();
            ex = (i >= 3) ? W'(i - 2) : '0;
            ev = (i >= 3) && (i - 3 != 5);
            n_checks++; if (xout !== ex) $display("FAIL ramp_x[%0d] got %0d exp %0d", i, xout, ex); else n_pass++;
            n_checks++; if (vout !== ev) $display("FAIL ramp_v[%0d] got %b exp %b", i, vout, ev); else n_pass++;
        end
    endtask

    task automatic test_settle();
        do_reset(3'd1);
        vin = 1'b1; yin = 12'd7;
        for (int j = 0; j < 12; j++) begin
            xin = W'(j + 1);
            if (j == 4) delay_sel = 3'd4;
            step();
            if (j >= 4 && j <= 8) begin
                n_checks++; if (settling !== 1'b1) $display("FAIL settle_flag[%0d] got %b exp 1", j, settling); else n_pass++;
                n_checks++; if (vout !== 1'b0) $display("FAIL settle_v[%0d] got %b exp 0", j, vout); else n_pass++;
            end
            if (j >= 9) begin
                n_checks++; if (settling !== 1'b0) $display("FAIL settle_done[%0d] got %b exp 0", j, settling); else n_pass++;
                n_checks++; if (vout !== 1'b1) $display("FAIL settle_after_v[%0d] got %b exp 1", j, vout); else n_pass++;
                n_checks++; if (xout !== W'(j - 3)) $display("FAIL settle_after_x[%0d] got %0d exp %0d", j, xout, j - 3); else n_pass++;
            end
        end
    endtask

    task automatic test_saturate();
        do_reset(3'd7);
        xin = 12'd50; yin = 12'd60; vin = 1'b1;
        step();
        vin = 1'b0; xin = 12'd0; yin = 12'd0;
        step(); step(); step();
        n_checks++; if (xout !== 12'd0) $display("FAIL sat_early_x got %0d exp 0", xout); else n_pass++;
        step();
        n_checks++; if (xout !== 12'd50) $display("FAIL sat_x got %0d exp 50", xout); else n_pass++;
        n_checks++; if (vout !== 1'b1) $display("FAIL sat_v got %b exp 1", vout); else n_pass++;
        delay_sel = 3'd4;
        step();
        n_checks++; if (settling !== 1'b0) $display("FAIL sat_same_settling got %b exp 0", settling); else n_pass++;
    endtask

    task automatic test_freeze();
        logic [W-1:0] ex;
        do_reset(3'd2);
        vin = 1'b1; yin = 12'd3;
        for (int j = 0; j < 11; j++) begin
            freeze = (j >= 5 && j <= 7);
            xin = freeze ? W'(100 + j) : W'(j + 1);
            step();
            if (j >= 5 && j <= 7) begin
                n_checks++; if (xout !== 12'd3) $display("FAIL frz_hold_x[%0d] got %0d exp 3", j, xout); else n_pass++;
                n_checks++; if (vout !== 1'b1) $display("FAIL frz_hold_v[%0d] got %b exp 1", j, vout); else n_pass++;
            end
            if (j >= 8) begin
                ex = (j == 8) ? 12'd4 : (j == 9) ? 12'd5 : 12'd9;
                n_checks++; if (xout !== ex) $display("FAIL frz_resume_x[%0d] got %0d exp %0d", j, xout, ex); else n_pass++;
            end
        end
        freeze = 1'b1; delay_sel = 3'd1;
        step();
        n_checks++; if (settling !== 1'b0) $display("FAIL frz_change_settling got %b exp 0", settling); else n_pass++;
        n_checks++; if (xout !== 12'd9) $display("FAIL frz_change_x got %0d exp 9", xout); else n_pass++;
        freeze = 1'b0;
        step();
        n_checks++; if (settling !== 1'b1) $display("FAIL unfrz_settling got %b exp 1", settling); else n_pass++;
        freeze = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; freeze = 1'b0;
        n_checks++; if (xout !== 12'd0) $display("FAIL rst_frz_x got %0d exp 0", xout); else n_pass++;
        n_checks++; if (yout !== 12'd0) $display("FAIL rst_frz_y got %0d exp 0", yout); else n_pass++;
        n_checks++; if (vout !== 1'b0) $display("FAIL rst_frz_v got %b exp 0", vout); else n_pass++;
        n_checks++; if (settling !== 1'b0) $display("FAIL rst_frz_settling got %b exp 0", settling); else n_pass++;
    endtask

`ifdef MOUSE_DELAY_MOVED_EN
    task automatic test_moved();
        logic [W-1:0] xs [4];
        logic         em [4];
        xs[0] = 12'd5; xs[1] = 12'd5; xs[2] = 12'd6; xs[3] = 12'd6;
        em[0] = 1'b1;  em[1] = 1'b0;  em[2] = 1'b1;  em[3] = 1'b0;
        do_reset(3'd0);
        n_checks++; if (moved !== 1'b0) $display("FAIL moved_reset got %b exp 0", moved); else n_pass++;
        vin = 1'b1; yin = 12'd0;
        for (int i = 0; i < 4; i++) begin
            xin = xs[i];
            step();
            n_checks++; if (moved !== em[i]) $display("FAIL moved[%0d] got %b exp %b", i, moved, em[i]); else n_pass++;
        end
    endtask
`endif

    initial begin
        rst = 1'b1; freeze = 1'b0; vin = 1'b0; xin = '0; yin = '0; delay_sel = '0;
        test_reset();
        test_delay0();
        test_clamp();
        test_ramp_d3();
        test_settle();
        test_saturate();
        test_freeze();
`ifdef MOUSE_DELAY_MOVED_EN
        test_moved();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
